ball_motion_gen: RTL and testbench
==================================

Name: ball_motion_gen

Overview:
- Produces the ball_x/ball_y coordinates consumed by the VGA display path.
- Writer side of the coordinate interface: advances ball position exactly once per video frame, paced by the display's vertical sync.
- Implements launch → flight under gravity → landing → hold → return-to-start FSM.

Parameters:
- X0, 100, start/rest x coordinate (pixels)
- Y0, 400, start/rest y coordinate (pixels, y grows downward)
- FLOOR_Y, 440, landing y; flight ends when y reaches/passes it
- X_MAX, 630, rightmost legal x
- GRAVITY, 1, added to vy each frame (pixels/frame²)
- HOLD_FRAMES, 30, frames ball rests at landing point before returning to X0,Y0

Ports:
- CLK100MHZ  input  1  system clock
- reset_n  input  1  synchronous reset, active-low
- VGA_VS  input  1  vertical sync from display path, active-low pulse, treated as asynchronous
- launch  input  1  single-cycle launch request
- vx_init  input  6  signed initial x velocity (pixels/frame)
- vy_init  input  8  signed initial y velocity (negative = upward)
- ball_x  output  10  ball x coordinate
- ball_y  output  10  ball y coordinate
- in_flight  output  1  high while in FLIGHT
- landed  output  1  one-cycle pulse on the landing update

Behaviour:
- Reset (reset_n low at CLK100MHZ edge): ball_x=X0, ball_y=Y0, in_flight=0, landed=0, vx=vy=0, hold counter=0, state IDLE, sync flops=1. Reset mid-flight aborts immediately.
- Frame tick: VGA_VS through 2-flop synchronizer, then falling-edge detect → frame_tick high for one cycle, 3 cycles after the VS falling edge is first sampled. One tick per frame.
- Coordinate outputs are registered; change only on the cycle after frame_tick (or on launch/return transitions listed below).
- Internal x, y: 12-bit signed; vx 6-bit signed; vy 8-bit signed, saturating at +127/-128.
- States:
  - IDLE: ball at X0,Y0. launch → load vx=vx_init, vy=vy_init, go FLIGHT, in_flight=1. No position change on the launch cycle. Launch coincident with frame_tick: launch wins; first motion on next tick.
  - FLIGHT, per tick: x_n=x+vx; y_n=y+vy; vy=vy+GRAVITY (saturating).
    - y_n ≥ FLOOR_Y → y=FLOOR_Y, x=clamped x_n, landed pulse, in_flight=0, go LANDED, hold counter=0.
    - y_n < 0 → y=0, vy=0.
    - x_n > X_MAX → x=X_MAX, right-wall rule (see Optional Feature).
    - x_n < 0 → x=0, left-wall rule.
    - Floor check takes priority over wall checks in the same tick; both clamps apply.
  - LANDED: hold counter increments per tick. On tick with counter==HOLD_FRAMES-1 → x=X0, y=Y0, go IDLE.
- launch outside IDLE is ignored (no queuing).
- ball_x/ball_y = low 10 bits of the clamped internal values, always in 0..X_MAX / 0..FLOOR_Y.

Optional Feature:
- Macro WALL_BOUNCE_EN.
- Defined: on a wall clamp, vx=-vx, so the ball reflects.
- Undefined: on a wall clamp, vx=0, so the ball drops vertically along the wall.

Test Plan:
- Reset: hold reset_n=0 for 5 cycles with VS toggling → ball_x=100, ball_y=400, in_flight=0, landed=0; no motion.
- Launch vx=5, vy=-10 → in_flight=1. Tick1: (105,390). Tick2: (110,381). Tick21: (205,400). Tick25: (225,440), landed one-cycle pulse, in_flight=0.
- Hold/return: after landing, 29 ticks keep (225,440); 30th tick → (100,400), state IDLE; a new launch is accepted.
- Wall, vx=31, vy=-20: tick17 x=627; tick18 x=630, y=193. Without WALL_BOUNCE_EN: tick19 x=630. With it: tick19 x=599.
- Launch ignored: pulse launch with vx=1 during FLIGHT → trajectory unchanged. Launch on the same cycle as frame_tick in IDLE → position unchanged that frame; moves on next tick.
- Mid-flight reset: reset_n=0 for 1 cycle at tick 10 → next cycle (100,400), in_flight=0, no landed pulse.

Source files
------------

// File: rtl/ball_motion_gen.sv
// ball_motion_gen: advances the ball position once per video frame, paced by
// the display's vertical sync. The ball is launched, flies under gravity, lands,
// rests for HOLD_FRAMES frames and then returns to its start point.
// Compile-time option: WALL_BOUNCE_EN. When it is defined, the ball reflects off
// the side walls. When it is undefined, the ball stops moving sideways at a wall
// and drops straight down along it.
module ball_motion_gen #(
  parameter int X0          = 100,
  parameter int Y0          = 400,
  parameter int FLOOR_Y     = 440,
  parameter int X_MAX       = 630,
  parameter int GRAVITY     = 1,
  parameter int HOLD_FRAMES = 30
) (
  input  logic              CLK100MHZ,
  input  logic              reset_n,
  input  logic              VGA_VS,
  input  logic              launch,
  input  logic signed [5:0] vx_init,
  input  logic signed [7:0] vy_init,
  output logic [9:0]        ball_x,
  output logic [9:0]        ball_y,
  output logic              in_flight,
  output logic              landed
);

  localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  localparam logic [9:0]         X0_10    = 10'(X0);
  localparam logic [9:0]         Y0_10    = 10'(Y0);
  localparam logic [9:0]         FLOOR_10 = 10'(FLOOR_Y);
  localparam logic [9:0]         XMAX_10  = 10'(X_MAX);
  localparam logic signed [11:0] FLOOR_12 = 12'(FLOOR_Y);
  localparam logic signed [11:0] XMAX_12  = 12'(X_MAX);
  localparam logic signed [8:0]  GRAV_9   = 9'(GRAVITY);
  localparam logic [HW-1:0]      HOLD_LAST = HW'(HOLD_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, FLIGHT, LANDED} state_t;

  state_t             state_reg;
  logic [9:0]         x_reg;
  logic [9:0]         y_reg;
  logic signed [5:0]  vx_reg;
  logic signed [7:0]  vy_reg;
  logic [HW-1:0]      hold_reg;

  logic vs_s1_reg, vs_s2_reg, vs_s3_reg;
  logic frame_tick_reg;

  logic signed [11:0] x_sum;
  logic signed [11:0] y_sum;
  logic signed [8:0]  vy_wide;
  logic signed [7:0]  vy_next;
  logic [9:0]         x_next;
  logic               wall_hit;
  logic signed [5:0]  vx_wall;

  assign ball_x = x_reg;
  assign ball_y = y_reg;

  // Synchronise VGA_VS and turn its falling edge into a one-cycle frame tick.
  always_ff @(posedge CLK100MHZ) begin
    if (!reset_n) begin
      vs_s1_reg      <= 1'b1;
      vs_s2_reg      <= 1'b1;
      vs_s3_reg      <= 1'b1;
      frame_tick_reg <= 1'b0;
    end else begin
      vs_s1_reg      <= VGA_VS;
      vs_s2_reg      <= vs_s1_reg;
      vs_s3_reg      <= vs_s2_reg;
      frame_tick_reg <= vs_s3_reg & ~vs_s2_reg;
    end
  end

  // Candidate position and velocity for the next frame, with wall clamps and
  // saturating gravity applied.
  always_comb begin
    x_sum   = $signed({2'b00, x_reg}) + $signed({{6{vx_reg[5]}}, vx_reg});
    y_sum   = $signed({2'b00, y_reg}) + $signed({{4{vy_reg[7]}}, vy_reg});
    vy_wide = $signed({vy_reg[7], vy_reg}) + GRAV_9;
    if (vy_wide > 9'sd127)
      vy_next = 8'sd127;
    else if (vy_wide < -9'sd128)
      vy_next = -8'sd128;
    else
      vy_next = vy_wide[7:0];
    wall_hit = 1'b1;
    if (x_sum[11])
      x_next = 10'd0;
    else if (x_sum > XMAX_12)
      x_next = XMAX_10;
    else begin
      x_next   = x_sum[9:0];
      wall_hit = 1'b0;
    end
`ifdef WALL_BOUNCE_EN
    // vx_init is limited to +/-31 in practice, so negation cannot overflow.
    vx_wall = -vx_reg;
`else
    vx_wall = 6'sd0;
`endif
  end

  // Launch / flight / landed / return state machine with registered outputs.
  always_ff @(posedge CLK100MHZ) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      x_reg     <= X0_10;
      y_reg     <= Y0_10;
      vx_reg    <= 6'sd0;
      vy_reg    <= 8'sd0;
      hold_reg  <= '0;
      in_flight <= 1'b0;
      landed    <= 1'b0;
    end else begin
      landed <= 1'b0;
      case (state_reg)
        IDLE: begin
          // Launch takes priority over a coincident frame tick.
          if (launch) begin
            vx_reg    <= vx_init;
            vy_reg    <= vy_init;
            in_flight <= 1'b1;
            state_reg <= FLIGHT;
          end
        end
        FLIGHT: begin
          if (frame_tick_reg) begin
            x_reg  <= x_next;
            vy_reg <= vy_next;
            if (wall_hit)
              vx_reg <= vx_wall;
            if (y_sum >= FLOOR_12) begin
              y_reg     <= FLOOR_10;
              landed    <= 1'b1;
              in_flight <= 1'b0;
              hold_reg  <= '0;
              state_reg <= LANDED;
            end else if (y_sum[11]) begin
              y_reg  <= 10'd0;
              vy_reg <= 8'sd0;
            end else begin
              y_reg <= y_sum[9:0];
            end
          end
        end
        LANDED: begin
          if (frame_tick_reg) begin
            if (hold_reg == HOLD_LAST) begin
              x_reg     <= X0_10;
              y_reg     <= Y0_10;
              hold_reg  <= '0;
              state_reg <= IDLE;
            end else begin
              hold_reg <= hold_reg + HW'(1);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_motion_gen.sv
// Testbench for ball_motion_gen: directed launches with hand-derived trajectories,
// checked by a scoreboard monitor after each frame update.
module tb_ball_motion_gen;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              vga_vs;
  logic              launch;
  logic signed [5:0] vx_in;
  logic signed [7:0] vy_in;
  logic [9:0]        ball_x;
  logic [9:0]        ball_y;
  logic              in_flight;
  logic              landed;

  ball_motion_gen dut (
    .CLK100MHZ(clk),
    .reset_n  (reset_n),
    .VGA_VS   (vga_vs),
    .launch   (launch),
    .vx_init  (vx_in),
    .vy_init  (vy_in),
    .ball_x   (ball_x),
    .ball_y   (ball_y),
    .in_flight(in_flight),
    .landed   (landed)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       f;
    logic [7:0] lc;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  event  sample_ev;
  int    checks = 0;
  int    errors = 0;

  int   landed_cnt = 0;
  int   wide_cnt   = 0;
  logic landed_prev = 1'b0;

  // Count landing pulses and any that last longer than one cycle.
  always @(negedge clk) begin
    if (landed) landed_cnt <= landed_cnt + 1;
    if (landed && landed_prev) wide_cnt <= wide_cnt + 1;
    landed_prev <= landed;
  end

  // Scoreboard monitor: compares DUT outputs against queued expectations.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(sample_ev);
      while (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (ball_x !== e.x || ball_y !== e.y || in_flight !== e.f || landed_cnt != int'(e.lc)) begin
          errors++;
          $display("FAIL %s: got x=%0d y=%0d fl=%0b lands=%0d, want x=%0d y=%0d fl=%0b lands=%0d",
                   nm, ball_x, ball_y, in_flight, landed_cnt, e.x, e.y, e.f, e.lc);
        end else begin
          $display("ok   %s: x=%0d y=%0d fl=%0b lands=%0d", nm, ball_x, ball_y, in_flight, landed_cnt);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  task automatic expect_state(input string nm, input int x, input int y, input bit f, input int lc);
    exp_t e;
    e.x  = 10'(x);
    e.y  = 10'(y);
    e.f  = f;
    e.lc = 8'(lc);
    exp_q.push_back(e);
    name_q.push_back(nm);
    -> sample_ev;
  endtask

  // One VS low pulse; the position update has settled when this returns.
  task automatic frame();
    @(negedge clk) vga_vs = 1'b0;
    repeat (4) @(negedge clk);
    vga_vs = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // VS pulse with launch asserted on the cycle the frame tick is consumed.
  task automatic frame_with_launch(input int vx, input int vy);
    @(negedge clk) vga_vs = 1'b0;
    repeat (3) @(negedge clk);
    launch = 1'b1; vx_in = 6'(vx); vy_in = 8'(vy);
    @(negedge clk);
    launch = 1'b0; vga_vs = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic launch_pulse(input int vx, input int vy);
    @(negedge clk);
    launch = 1'b1; vx_in = 6'(vx); vy_in = 8'(vy);
    @(negedge clk);
    launch = 1'b0;
  endtask

  task automatic reset_pulse();
    @(negedge clk) reset_n = 1'b0;
    @(negedge clk) reset_n = 1'b1;
  endtask

  // Closed-form height after n frames with gravity 1 and no ceiling contact.
  function automatic int y_at(input int y0, input int vy0, input int n);
    return y0 + vy0 * n + (n * (n - 1)) / 2;
  endfunction

  initial begin
    int ey;
    int ex;
    reset_n = 1'b0; vga_vs = 1'b1; launch = 1'b0; vx_in = '0; vy_in = '0;

    // Reset while VS toggles.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vga_vs = ~vga_vs;
    end
    @(negedge clk) vga_vs = 1'b1;
    expect_state("reset", 100, 400, 0, 0);
    @(negedge clk) reset_n = 1'b1;
    frame();
    expect_state("idle_tick", 100, 400, 0, 0);

    // Flight 1: vx=5, vy=-10, with a stray launch during flight.
    launch_pulse(5, -10);
    expect_state("launch1", 100, 400, 1, 0);
    for (int n = 1; n <= 25; n++) begin
      if (n == 3) launch_pulse(1, 0);
      frame();
      ey = (n == 25) ? 440 : y_at(400, -10, n);
      expect_state($sformatf("f1_t%0d", n), 100 + 5 * n, ey, n < 25, (n == 25) ? 1 : 0);
    end

    // Hold for 29 frames, return on the 30th.
    for (int k = 1; k <= 30; k++) begin
      frame();
      if (k < 30) expect_state($sformatf("hold_%0d", k), 225, 440, 0, 1);
      else        expect_state("return", 100, 400, 0, 1);
    end

    // Launch coincident with a frame tick, then reset mid-flight at tick 10.
    frame_with_launch(5, -10);
    expect_state("coinc_launch", 100, 400, 1, 1);
    for (int n = 1; n <= 10; n++) begin
      frame();
      expect_state($sformatf("f2_t%0d", n), 100 + 5 * n, y_at(400, -10, n), 1, 1);
    end
    reset_pulse();
    expect_state("midflight_reset", 100, 400, 0, 1);

    // Right wall: vx=31, vy=-20.
    launch_pulse(31, -20);
    for (int n = 1; n <= 43; n++) begin
      frame();
      if (n <= 17) begin
        expect_state($sformatf("w_t%0d", n), 100 + 31 * n, y_at(400, -20, n), 1, 1);
      end else if (n == 18) begin
        expect_state("w_t18", 630, 193, 1, 1);
      end else if (n == 19) begin
`ifdef WALL_BOUNCE_EN
        ex = 599;
`else
        ex = 630;
`endif
        expect_state("w_t19", ex, y_at(400, -20, 19), 1, 1);
      end else if (n == 43) begin
`ifdef WALL_BOUNCE_EN
        ex = 124;
`else
        ex = 630;
`endif
        expect_state("w_land", ex, 440, 0, 2);
      end
    end
    reset_pulse();
    expect_state("w_reset", 100, 400, 0, 2);

    // Ceiling: vy=-128 reaches y<0 on tick 4.
    launch_pulse(0, -128);
    for (int n = 1; n <= 7; n++) begin
      frame();
      case (n)
        1: ey = 272;
        2: ey = 145;
        3: ey = 19;
        4: ey = 0;
        5: ey = 0;
        6: ey = 1;
        default: ey = 3;
      endcase
      expect_state($sformatf("c_t%0d", n), 100, ey, 1, 2);
    end
    reset_pulse();
    expect_state("c_reset", 100, 400, 0, 2);

    repeat (2) @(negedge clk);
    checks++;
    if (wide_cnt != 0) begin
      errors++;
      $display("FAIL landed_width: got %0d multi-cycle pulses, want 0", wide_cnt);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
